rev_cascade_sequencer: RTL and testbench

- Sequences a programmable cascade of multiple-control Toffoli (MCT) gates over a WIDTH-line register, applying one gate per clock.
- Gate program is held in a small internal memory. Runs forward (gate 0 to len-1) or in reverse (len-1 to 0); a reverse run of the same program undoes a forward run.
- Sits above the fixed reversible gate primitives as the controller that turns them into a configurable reversible function unit inside the ALU.

---
 rtl/rev_seq_pkg.sv | 20 ++
 rtl/rev_mct_gate.sv | 24 ++
 rtl/rev_cascade_sequencer.sv | 114 +++++++++++
 tb/tb_rev_cascade_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/rev_seq_pkg.sv
// Shared types and gate-word helpers for the reversible cascade sequencer.
package rev_seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Widest gate word the helpers accept; callers zero-extend into it.
  localparam int unsigned GATE_WORD_MAX = 64;

  // Gate word layout is {ctrl_mask, target}; tw is the target field width.
  function automatic logic [GATE_WORD_MAX-1:0] gate_mask(input logic [GATE_WORD_MAX-1:0] word,
                                                         input int unsigned tw);
    return word >> tw;
  endfunction

  function automatic logic [GATE_WORD_MAX-1:0] gate_target(input logic [GATE_WORD_MAX-1:0] word,
                                                           input int unsigned tw);
    return word & ((GATE_WORD_MAX'(1) << tw) - GATE_WORD_MAX'(1));
  endfunction

endpackage

// File: rtl/rev_mct_gate.sv
// Combinational multiple-control Toffoli gate over WIDTH lines.
module rev_mct_gate #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned TW    = 2
) (
  input  logic [WIDTH-1:0] lines,
  input  logic [WIDTH-1:0] mask,
  input  logic [TW-1:0]    target,
  output logic [WIDTH-1:0] lines_out
);

  logic [WIDTH-1:0] tbit;
  logic [WIDTH-1:0] mask_eff;
  logic             fire;

  // An out-of-range target shifts to zero, which makes the gate a no-op.
  always_comb begin
    tbit      = WIDTH'(1) << target;
    mask_eff  = mask & ~tbit;
    fire      = &(lines | ~mask_eff);
    lines_out = fire ? (lines ^ tbit) : lines;
  end

endmodule

// File: rtl/rev_cascade_sequencer.sv
// Runs a stored MCT gate program forward or in reverse, one gate per clock.
module rev_cascade_sequencer
  import rev_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       prog_we,
  input  logic [$clog2(DEPTH)-1:0]   prog_addr,
  input  logic [WIDTH+$clog2(WIDTH)-1:0] prog_wdata,
  input  logic [$clog2(DEPTH):0]     prog_len,
  input  logic                       start,
  input  logic                       dir,
  input  logic [WIDTH-1:0]           din,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH)-1:0]   step_idx
);

  localparam int unsigned TW = $clog2(WIDTH);
  localparam int unsigned GW = WIDTH + TW;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  state_t          state;
  logic [AW-1:0]   idx;
  logic [LW-1:0]   len_q;
  logic            dir_q;

  logic [GW-1:0]   mem [DEPTH];
  logic [GW-1:0]   cur_word;
  logic [WIDTH-1:0] cur_mask;
  logic [TW-1:0]   cur_target;
  logic [WIDTH-1:0] gate_lines;
  logic [LW-1:0]   len_c;
  logic            last_c;

  // Program memory is deliberately outside reset; writes only land while idle.
  always_ff @(posedge clk) begin
    if (prog_we && state == IDLE) mem[prog_addr] <= prog_wdata;
  end

  always_comb begin
    cur_word   = mem[idx];
    cur_mask   = WIDTH'(gate_mask(GATE_WORD_MAX'(cur_word), TW));
    cur_target = TW'(gate_target(GATE_WORD_MAX'(cur_word), TW));
    len_c      = (prog_len > LW'(DEPTH)) ? LW'(DEPTH) : prog_len;
    last_c     = dir_q ? (idx == '0) : (LW'(idx) == len_q - LW'(1));
  end

  rev_mct_gate #(.WIDTH(WIDTH), .TW(TW)) u_gate (
    .lines     (dout),
    .mask      (cur_mask),
    .target    (cur_target),
    .lines_out (gate_lines)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      dout     <= '0;
      step_idx <= '0;
      idx      <= '0;
      len_q    <= '0;
      dir_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            dout  <= din;
            len_q <= len_c;
            dir_q <= dir;
            busy  <= 1'b1;
            // Reverse starts at the last gate; an empty program never underflows.
            idx   <= (dir && len_c != '0) ? AW'(len_c - LW'(1)) : '0;
            if (len_c == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          dout     <= gate_lines;
          step_idx <= idx;
          if (last_c) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            idx <= dir_q ? idx - AW'(1) : idx + AW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rev_cascade_sequencer.sv
// Scoreboard bench for rev_cascade_sequencer with a behavioural gate-list model.
module tb_rev_cascade_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [5:0] prog_wdata;
  logic [4:0] prog_len;
  logic       start;
  logic       dir;
  logic [3:0] din;
  logic       busy;
  logic       done;
  logic [3:0] dout;
  logic [3:0] step_idx;

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;
  logic [3:0] sb[$];
  logic [5:0] model_mem [16];
  logic [5:0] co_word;

  rev_cascade_sequencer #(.WIDTH(4), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .prog_len(prog_len), .start(start), .dir(dir),
    .din(din), .busy(busy), .done(done), .dout(dout), .step_idx(step_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      done_cnt++;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected_done: got dout %b expected no done", dout);
      end else begin
        logic [3:0] e;
        e = sb.pop_front();
        if (dout !== e) begin
          miscompares++;
          $display("FAIL sb_dout: got %b expected %b", dout, e);
        end
      end
    end
  end

  // Reference: apply the listed gates in program order, line by line.
  function automatic logic [3:0] model_run(input logic [3:0] d, input int len, input bit rev);
    int n;
    logic [3:0] v;
    n = (len > 16) ? 16 : len;
    v = d;
    for (int k = 0; k < n; k++) begin
      logic [5:0] g;
      int t;
      bit all;
      g = rev ? model_mem[n-1-k] : model_mem[k];
      t = int'(g[1:0]);
      all = 1'b1;
      for (int i = 0; i < 4; i++)
        if (i != t && g[i+2] && !v[i]) all = 1'b0;
      if (all) v[t] = ~v[t];
    end
    return v;
  endfunction

  task automatic write_gate(input int a, input logic [3:0] m, input logic [1:0] t);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = 4'(a); prog_wdata = {m, t};
    @(posedge clk); #1;
    prog_we = 1'b0;
    model_mem[a] = {m, t};
  endtask

  // poke: 0 none, 1 start mid-run, 2 write mem[1] mid-run, 3 write mem[0] with start
  task automatic run(input logic [3:0] d, input int len, input bit rev,
                     input logic [3:0] exp, input int poke, input int poke_at);
    int eff, cycles, bcnt, d0;
    bit seen, stepok;
    eff = (len > 16) ? 16 : len;
    sb.push_back(exp);
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; din = d; prog_len = 5'(len); dir = rev;
    if (poke == 3) begin
      prog_we = 1'b1; prog_addr = 4'd0; prog_wdata = co_word;
    end
    @(posedge clk); #1;
    start = 1'b0; prog_we = 1'b0;
    cycles = 0; bcnt = 0; seen = 1'b0; stepok = 1'b1;
    while (!seen && cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (poke == 1 || poke == 2) begin
        if (cycles == poke_at + 1) begin start = 1'b0; prog_we = 1'b0; end
        if (cycles == poke_at) begin
          if (poke == 1) begin start = 1'b1; din = ~d; end
          else begin prog_we = 1'b1; prog_addr = 4'd1; prog_wdata = 6'b0000_11; end
        end
      end
      if (busy) bcnt++;
      if (cycles >= 2 && cycles <= eff + 1) begin
        int ei;
        ei = rev ? (eff - 1 - (cycles - 2)) : (cycles - 2);
        if (int'(step_idx) != ei) stepok = 1'b0;
      end
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      vectors++; miscompares++;
      $display("FAIL run_timeout: got no done expected done within 100 cycles");
      return;
    end
    check("latency", 32'(cycles), 32'(eff + 1));
    check("busy_cycles", 32'(bcnt), 32'(eff + 1));
    if (eff > 0) check("step_seq", 32'(stepok), 32'd1);
    @(negedge clk);
    start = 1'b0; prog_we = 1'b0;
    check("post_done_idle", {30'd0, busy, done}, 32'd0);
    check("done_once", 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    logic [3:0] f, d;
    int len;
    bit rev;
    rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    prog_len = '0; start = 1'b0; dir = 1'b0; din = '0; co_word = '0;
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_dout", 32'(dout), 32'd0);
    check("reset_step", 32'(step_idx), 32'd0);
    rst_n = 1'b1;

    // Fill memory so the model and DUT agree everywhere.
    for (int i = 0; i < 16; i++) write_gate(i, 4'b0000, 2'b00);

    // Single Toffoli
    write_gate(0, 4'b0111, 2'b11);
    run(4'b0111, 1, 1'b0, 4'b1111, 0, 0);
    run(4'b0011, 1, 1'b0, 4'b0011, 0, 0);

    // Cascade forward and reverse
    write_gate(0, 4'b0000, 2'b00);
    write_gate(1, 4'b0001, 2'b01);
    write_gate(2, 4'b0011, 2'b10);
    run(4'b0000, 3, 1'b0, 4'b0111, 0, 0);
    run(4'b0111, 3, 1'b1, 4'b0000, 0, 0);
    for (int i = 0; i < 16; i++) begin
      d = 4'(i);
      f = model_run(d, 3, 1'b0);
      run(d, 3, 1'b0, f, 0, 0);
      run(f, 3, 1'b1, d, 0, 0);
    end

    // Empty program
    run(4'b1010, 0, 1'b0, 4'b1010, 0, 0);
    run(4'b0110, 0, 1'b1, 4'b0110, 0, 0);

    // Busy protection: start mid-run, start during done, write mid-run
    run(4'b0000, 3, 1'b0, 4'b0111, 1, 2);
    run(4'b0000, 3, 1'b0, 4'b0111, 1, 4);
    run(4'b0000, 3, 1'b0, 4'b0111, 2, 2);
    run(4'b0000, 3, 1'b0, 4'b0111, 0, 0);
    check("mem1_preserved_fwd_rev", 32'(model_run(4'b0111, 3, 1'b1)), 32'd0);

    // Self-control on the target is ignored
    write_gate(0, 4'b1000, 2'b11);
    run(4'b0000, 1, 1'b0, 4'b1000, 0, 0);

    // Write and start in the same idle cycle: run sees the new word
    co_word = {4'b0000, 2'b01};
    model_mem[0] = co_word;
    run(4'b0000, 1, 1'b0, 4'b0010, 3, 0);

    // Full-depth random program in both directions, plus clamp
    for (int i = 0; i < 16; i++) write_gate(i, 4'($urandom), 2'($urandom));
    d = 4'($urandom);
    f = model_run(d, 16, 1'b0);
    run(d, 16, 1'b0, f, 0, 0);
    run(f, 16, 1'b1, d, 0, 0);
    run(d, 31, 1'b0, f, 0, 0);

    // Reset during the second gate of a len=8 run
    @(negedge clk);
    start = 1'b1; din = 4'hF; prog_len = 5'd8; dir = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_dout", 32'(dout), 32'd0);
    check("rst_mid_step", 32'(step_idx), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    run(4'hF, 8, 1'b0, model_run(4'hF, 8, 1'b0), 0, 0);

    // Randomised runs with periodic reprogramming
    for (int r = 0; r < 40; r++) begin
      if (r % 10 == 0)
        for (int i = 0; i < 16; i++) write_gate(i, 4'($urandom), 2'($urandom));
      d   = 4'($urandom);
      len = int'($urandom_range(0, 20));
      rev = 1'($urandom);
      run(d, len, rev, model_run(d, len, rev), 0, 0);
    end

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
